bt_64_seq_divider: RTL and testbench

Multi-cycle integer divider for the 64-bit ALU. It runs restoring shift-subtract iterations, one quotient bit per clock, and is the iterative inverse of the 64-bit add/subtract datapath. The datapath is an add/subtract with carry-out used as the "no borrow" test. It supports signed (truncating) and unsigned division and uses a start/busy/done handshake toward the ALU control.

---
 rtl/bt_64_seq_divider.sv | 126 ++++++++++++
 tb/tb_bt_64_seq_divider.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bt_64_seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, signed (truncating) or unsigned,
// with a start/busy/done handshake toward the ALU control.
module bt_64_seq_divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] prem;      // partial remainder
    logic [WIDTH-1:0] dq;        // dividend magnitude, quotient bits shift in at the LSB
    logic [WIDTH-1:0] dvs_mag;
    logic             neg_quo;
    logic             neg_rem;
    logic             ovf_case;
    logic [CW-1:0]    cnt;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             no_borrow;
    logic             is_min_neg;
    logic             is_all_ones;

    always_comb begin
        dvd_neg     = is_signed & dividend[WIDTH-1];
        dvs_neg     = is_signed & divisor[WIDTH-1];
        dvd_abs     = dvd_neg ? (~dividend + 1'b1) : dividend;
        dvs_abs     = dvs_neg ? (~divisor + 1'b1) : divisor;
        is_min_neg  = (dividend == {1'b1, {(WIDTH-1){1'b0}}});
        is_all_ones = (divisor == {WIDTH{1'b1}});
        // The shifted remainder can reach WIDTH+1 bits; the extra top bit of diff is the borrow.
        shifted     = {prem, dq[WIDTH-1]};
        diff        = {1'b0, shifted} - {2'b00, dvs_mag};
        no_borrow   = ~diff[WIDTH+1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            prem        <= '0;
            dq          <= '0;
            dvs_mag     <= '0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            ovf_case    <= 1'b0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '0;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            prem        <= '0;
                            dq          <= dvd_abs;
                            dvs_mag     <= dvs_abs;
                            neg_quo     <= dvd_neg ^ dvs_neg;
                            neg_rem     <= dvd_neg;
                            ovf_case    <= is_signed & is_min_neg & is_all_ones;
                            cnt         <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b0;
                            busy        <= 1'b1;
                            state       <= RUN;
                        end
                    end
                end
                RUN: begin
                    prem <= no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    dq   <= {dq[WIDTH-2:0], no_borrow};
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    quotient  <= neg_quo ? (~dq + 1'b1) : dq;
                    remainder <= neg_rem ? (~prem + 1'b1) : prem;
                    overflow  <= ovf_case;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bt_64_seq_divider.sv
// Directed bench for bt_64_seq_divider: table of hand-computed vectors plus
// handshake, flag-hold, ignored-start and mid-run reset sequences.
module tb_bt_64_seq_divider;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        busy;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    bt_64_seq_divider #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sgn;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] q;
        logic [63:0] r;
        logic        dbz;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Launch one operation and wait for done; lat is the done cycle (start cycle = 0), -1 on timeout.
    task automatic run_op(input logic s, input logic [63:0] a, input logic [63:0] b,
                          input bit poke, output int lat, output int bad_busy);
        logic exp_busy;
        @(negedge clk);
        is_signed = s; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; dividend = ~a; divisor = 64'd3; is_signed = ~s;
        lat = -1;
        bad_busy = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (poke && c == 10) begin
                start = 1'b1; dividend = 64'd5; divisor = 64'd3; is_signed = 1'b0;
            end
            if (poke && c == 11) start = 1'b0;
            exp_busy = (b != 64'd0) && (c <= 65);
            if (busy !== exp_busy) bad_busy++;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int lat;
        int bad_busy;
        int cnt;

        vecs[0] = '{"u_100_7",    1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0, 66};
        vecs[1] = '{"s_m100_7",   1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
                    64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 66};
        vecs[2] = '{"s_100_m7",   1'b1, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9,
                    64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b0, 1'b0, 66};
        vecs[3] = '{"u_dbz",      1'b0, 64'h1234, 64'd0, 64'd0, 64'h1234, 1'b1, 1'b0, 1};
        vecs[4] = '{"s_dbz",      1'b1, 64'h1234, 64'd0, 64'd0, 64'h1234, 1'b1, 1'b0, 1};
        vecs[5] = '{"s_ovf",      1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b1, 66};
        vecs[6] = '{"u_minneg",   1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 66};
        vecs[7] = '{"u_ones_1",   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0, 66};
        vecs[8] = '{"s_m7_m2",    1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE,
                    64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 66};
        vecs[9] = '{"u_ones_16",  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10,
                    64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 1'b0, 1'b0, 66};

        reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_q", quotient, 64'd0);
        chk("rst_r", remainder, 64'd0);
        chk("rst_flags", {62'd0, div_by_zero, overflow}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b0, lat, bad_busy);
            chk({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].lat));
            chk({vecs[i].name, "_busy"}, 64'(bad_busy), 64'd0);
            chk({vecs[i].name, "_q"}, quotient, vecs[i].q);
            chk({vecs[i].name, "_r"}, remainder, vecs[i].r);
            chk({vecs[i].name, "_flags"}, {62'd0, div_by_zero, overflow},
                {62'd0, vecs[i].dbz, vecs[i].ovf});
        end

        // Results and flags hold after done; flags clear one cycle after the next acceptance.
        run_op(1'b0, 64'h1234, 64'd0, 1'b0, lat, bad_busy);
        repeat (3) @(negedge clk);
        chk("hold_done", {63'd0, done}, 64'd0);
        chk("hold_dbz", {63'd0, div_by_zero}, 64'd1);
        chk("hold_r", remainder, 64'h1234);
        is_signed = 1'b0; dividend = 64'd100; divisor = 64'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("clr_dbz", {63'd0, div_by_zero}, 64'd0);
        chk("clr_busy", {63'd0, busy}, 64'd1);
        chk("old_q", quotient, 64'd0);
        chk("old_r", remainder, 64'h1234);
        lat = -1;
        for (int c = 2; c <= 200; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        chk("seq_lat", 64'(lat), 64'd66);
        chk("seq_q", quotient, 64'd14);

        // start during RUN is ignored.
        run_op(1'b0, 64'd1000, 64'd9, 1'b1, lat, bad_busy);
        chk("poke_lat", 64'(lat), 64'd66);
        chk("poke_busy", 64'(bad_busy), 64'd0);
        chk("poke_q", quotient, 64'd111);
        chk("poke_r", remainder, 64'd1);
        repeat (3) @(negedge clk);
        chk("poke_nodone", {63'd0, done}, 64'd0);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        is_signed = 1'b0; dividend = 64'd100; divisor = 64'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (30) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_q", quotient, 64'd0);
        chk("arst_r", remainder, 64'd0);
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) cnt++;
        end
        chk("arst_quiet", 64'(cnt), 64'd0);
        reset = 1'b0;
        cnt = 0;
        repeat (70) begin
            @(negedge clk);
            if (done !== 1'b0) cnt++;
        end
        chk("arst_nodone", 64'(cnt), 64'd0);
        run_op(1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b0, lat, bad_busy);
        chk("post_lat", 64'(lat), 64'd66);
        chk("post_q", quotient, 64'hFFFF_FFFF_FFFF_FFF2);
        chk("post_r", remainder, 64'hFFFF_FFFF_FFFF_FFFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
